imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
Instruction-memory controller that sits directly upstream of the fetch stage. It takes the fetch stage's next_pc each cycle and routes the read to one of two targets: the on-core ITCM (synchronous SRAM) or an AHB-Lite master port for external memory. It returns instr_read_data with a single-cycle instr_read_data_valid pulse, and flags AHB-sourced and faulted fetches.

Parameters:
ADDR_WIDTH, 32, byte address width
INSTR_WIDTH, 32, instruction/data width
ITCM_BASE, 32'h0000_0000, ITCM region base (aligned to region size)
ITCM_AW, 14, ITCM word-address width; region size = 4<<ITCM_AW bytes
FAULT_INSTR, 32'h0000_0013, instruction returned on AHB error (NOP)

Ports:
cpu_clk  in  1  cpu clock
cpu_rstn  in  1  asynchronous active-low reset
next_pc  in  ADDR_WIDTH  fetch address from fetch stage
instr_read_data_valid  out  1  one-cycle pulse: instr_read_data is valid
instr_read_data  out  INSTR_WIDTH  fetched instruction
addr_AHB  out  1  returning/in-flight fetch targets AHB
instr_access_fault  out  1  qualifies valid: AHB returned ERROR
itcm_cs  out  1  ITCM read strobe
itcm_addr  out  ITCM_AW  ITCM word address
itcm_rdata  in  INSTR_WIDTH  ITCM read data, one cycle after strobe
HADDR  out  ADDR_WIDTH  AHB address
HTRANS  out  2  IDLE=00, NONSEQ=10 only
HWRITE  out  1  constant 0
HSIZE  out  3  constant 3'b010
HBURST  out  3  constant SINGLE 3'b000
HPROT  out  4  constant 4'b0010 (opcode fetch, privileged)
HRDATA  in  INSTR_WIDTH  AHB read data
HREADY  in  1  AHB transfer ready
HRESP  in  1  AHB error response

Behaviour:
- Region decode: in_itcm = (next_pc & ~((4<<ITCM_AW)-1)) == ITCM_BASE. Fetch address is always word-aligned (next_pc[1:0] ignored). Misalignment is reported by the fetch stage.
- Issue condition: a request is issued in any cycle where no request is outstanding, or where the outstanding request returns (instr_read_data_valid=1). The issued address is next_pc sampled in that cycle. Exactly one request is outstanding at a time.
- The first request issues in the first cycle after reset release, at next_pc (boot_addr).
- ITCM path: in the issue cycle, drive itcm_cs=1 and itcm_addr=next_pc[ITCM_AW+1:2] combinationally. Set itcm_pend. In the next cycle, assert instr_read_data_valid=1 and pass instr_read_data=itcm_rdata through, with addr_AHB=0 and instr_access_fault=0. Back-to-back ITCM fetches sustain 1 instruction per cycle.
- AHB path FSM, states IDLE/ADDR/DATA/RESP:
  - Issue to AHB: latch word-aligned address into haddr_r and go to ADDR.
  - ADDR: HTRANS=NONSEQ, HADDR=haddr_r. Go to DATA on HREADY=1, otherwise hold with the address stable.
  - DATA: HTRANS=IDLE. On HREADY=1, register HRDATA (or FAULT_INSTR if HRESP=1) and the fault flag, then go to RESP.
  - DATA with HRESP=1 and HREADY=0 (first error cycle): stay in DATA, HTRANS=IDLE.
  - RESP: instr_read_data_valid=1, addr_AHB=1, instr_access_fault=registered flag. A new issue in this cycle goes to ADDR (AHB) or drives ITCM; with no issue, go to IDLE.
  - Zero-wait latency is 3 cycles from issue to valid. Each HREADY-low cycle adds one.
- addr_AHB is high from the issue of an AHB request through its RESP cycle, and low otherwise.
- Region switch (ITCM to AHB or back) happens only at the valid/issue cycle. There is no overlap between targets.
- HTRANS is never NONSEQ outside ADDR. HWRITE, HSIZE, HBURST and HPROT are constant.
- Reset values: instr_read_data_valid=0, instr_read_data=0, addr_AHB=0, instr_access_fault=0, itcm_cs=0, HTRANS=IDLE, HADDR=0, FSM=IDLE, itcm_pend=0.
- Reset mid-transfer: all state clears immediately. An AHB transfer in flight is abandoned, and the next request issues after reset release.
- There is no flush input. A stale response is still delivered, and the fetch stage discards it.

Test Plan:
- Reset release with next_pc=0x0000_0000 (ITCM) and itcm_rdata=0x0000_0093 -> itcm_cs=1 in cycle 1, valid=1 with data 0x93 in cycle 2. Consecutive addresses 0x0, 0x4, 0x8 -> valid on 3 consecutive cycles, itcm_addr=0, 1, 2.
- next_pc=0x8000_0000 (AHB), zero-wait, HRDATA=0x0010_0513 -> HTRANS=NONSEQ, HADDR=0x8000_0000 one cycle after issue; valid=1, addr_AHB=1, data 0x0010_0513 three cycles after issue.
- Same AHB fetch with HREADY low for 2 cycles in ADDR and 3 in DATA -> HADDR stays stable; valid arrives exactly 8 cycles after issue, as a single pulse.
- AHB ERROR (HRESP=1, HREADY=0 then HRESP=1, HREADY=1) -> HTRANS=IDLE during error; valid=1, instr_access_fault=1, data 0x0000_0013.
- Alternating ITCM 0x100 then AHB 0x8000_0200 then ITCM 0x104 -> no overlapping requests; addr_AHB toggles 0/1/0 aligned to each valid; every request returns exactly once.
- Assert cpu_rstn low while in DATA -> all outputs return to reset values the same cycle. After release, a fresh request issues at next_pc.

Source files
------------

// File: rtl/imem_ctrl.sv
// Instruction-memory controller feeding the fetch stage.
// Each fetch address is routed either to the tightly-coupled ITCM (1-cycle
// synchronous SRAM) or to a single-beat AHB-Lite read. Only one fetch is ever
// outstanding. A new fetch may issue in the same cycle that the previous one
// returns, so the ITCM path sustains one instruction per cycle.
module imem_ctrl #(
   parameter int                      ADDR_WIDTH  = 32,
   parameter int                      INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]   ITCM_BASE   = 32'h0000_0000,
   parameter int                      ITCM_AW     = 14,
   parameter logic [INSTR_WIDTH-1:0]  FAULT_INSTR = 32'h0000_0013
) (
   input  logic                    cpu_clk,
   input  logic                    cpu_rstn,
   input  logic [ADDR_WIDTH-1:0]   next_pc,
   output logic                    instr_read_data_valid,
   output logic [INSTR_WIDTH-1:0]  instr_read_data,
   output logic                    addr_AHB,
   output logic                    instr_access_fault,
   output logic                    itcm_cs,
   output logic [ITCM_AW-1:0]      itcm_addr,
   input  logic [INSTR_WIDTH-1:0]  itcm_rdata,
   output logic [ADDR_WIDTH-1:0]   HADDR,
   output logic [1:0]              HTRANS,
   output logic                    HWRITE,
   output logic [2:0]              HSIZE,
   output logic [2:0]              HBURST,
   output logic [3:0]              HPROT,
   input  logic [INSTR_WIDTH-1:0]  HRDATA,
   input  logic                    HREADY,
   input  logic                    HRESP
);

   // ITCM region covers (4 << ITCM_AW) bytes starting at ITCM_BASE
   localparam logic [ADDR_WIDTH-1:0] ONE_A     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ITCM_SIZE = ONE_A << (ITCM_AW + 2);
   localparam logic [ADDR_WIDTH-1:0] ITCM_MASK = ~(ITCM_SIZE - ONE_A);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ADDR = 2'b01,
      S_DATA = 2'b10,
      S_RESP = 2'b11
   } ahb_state_t;

   ahb_state_t               r_state;
   ahb_state_t               w_state_nxt;
   logic                     r_itcm_pend;
   logic [ADDR_WIDTH-1:0]    r_haddr;
   logic [INSTR_WIDTH-1:0]   r_hrdata;
   logic                     r_fault;

   logic                     w_in_itcm;
   logic                     w_issue;
   logic                     w_issue_itcm;
   logic                     w_issue_ahb;

   // Region decode and issue decision; an issue is allowed whenever nothing
   // is outstanding or the outstanding fetch returns this cycle. Gating with
   // cpu_rstn keeps the ITCM strobe quiet while reset is held.
   always_comb begin
      w_in_itcm    = ((next_pc & ITCM_MASK) == ITCM_BASE);
      w_issue      = cpu_rstn & ((r_state == S_IDLE) | (r_state == S_RESP));
      w_issue_itcm = w_issue & w_in_itcm;
      w_issue_ahb  = w_issue & ~w_in_itcm;
   end

   // AHB fetch FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_issue_ahb) w_state_nxt = S_ADDR;
            else             w_state_nxt = S_IDLE;
         end
         S_ADDR: begin
            if (HREADY) w_state_nxt = S_DATA;
            else        w_state_nxt = S_ADDR;
         end
         S_DATA: begin
            // an ERROR first cycle (HREADY low) simply holds here
            if (HREADY) w_state_nxt = S_RESP;
            else        w_state_nxt = S_DATA;
         end
         S_RESP: begin
            if (w_issue_ahb) w_state_nxt = S_ADDR;
            else             w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // AHB FSM state register
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Fetch bookkeeping: ITCM pending flag, latched AHB address, captured response
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_itcm_pend <= 1'b0;
         r_haddr     <= {ADDR_WIDTH{1'b0}};
         r_hrdata    <= {INSTR_WIDTH{1'b0}};
         r_fault     <= 1'b0;
      end else begin
         r_itcm_pend <= w_issue_itcm;
         if (w_issue_ahb) begin
            r_haddr <= {next_pc[ADDR_WIDTH-1:2], 2'b00};
         end
         if ((r_state == S_DATA) && HREADY) begin
            r_hrdata <= HRESP ? FAULT_INSTR : HRDATA;
            r_fault  <= HRESP;
         end
      end
   end

   // Response mux back to the fetch stage; an ITCM return owns the cycle, so
   // addr_AHB reports the returning target before any newly issued one
   always_comb begin
      instr_read_data_valid = r_itcm_pend | (r_state == S_RESP);
      instr_access_fault    = (r_state == S_RESP) & r_fault;
      if (r_itcm_pend) begin
         instr_read_data = itcm_rdata;
         addr_AHB        = 1'b0;
      end else if (r_state == S_RESP) begin
         instr_read_data = r_hrdata;
         addr_AHB        = 1'b1;
      end else begin
         instr_read_data = {INSTR_WIDTH{1'b0}};
         addr_AHB        = (r_state != S_IDLE) | w_issue_ahb;
      end
   end

   // ITCM strobe and word address presented in the issue cycle
   always_comb begin
      itcm_cs   = w_issue_itcm;
      itcm_addr = next_pc[ITCM_AW+1:2];
   end

   // AHB address-phase signals; NONSEQ only while in the address phase
   always_comb begin
      HADDR = r_haddr;
      if (r_state == S_ADDR) HTRANS = HTRANS_NONSEQ;
      else                   HTRANS = HTRANS_IDLE;
   end

   assign HWRITE = 1'b0;
   assign HSIZE  = 3'b010;
   assign HBURST = 3'b000;
   assign HPROT  = 4'b0010;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: directed scenarios plus a randomized
// run checked against a transaction-level latency model.
module tb_imem_ctrl;

   logic        cpu_clk = 1'b0;
   logic        cpu_rstn;
   logic [31:0] next_pc;
   logic [31:0] itcm_rdata;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   logic        instr_read_data_valid;
   logic [31:0] instr_read_data;
   logic        addr_AHB;
   logic        instr_access_fault;
   logic        itcm_cs;
   logic [13:0] itcm_addr;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;

   int n_chk  = 0;
   int n_fail = 0;

   // slave timing for the next AHB transfer: address-phase waits, data-phase
   // waits, error response
   int cfg_aw  = 0;
   int cfg_dw  = 0;
   bit cfg_err = 1'b0;

   imem_ctrl dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .next_pc(next_pc),
      .instr_read_data_valid(instr_read_data_valid), .instr_read_data(instr_read_data),
      .addr_AHB(addr_AHB), .instr_access_fault(instr_access_fault),
      .itcm_cs(itcm_cs), .itcm_addr(itcm_addr), .itcm_rdata(itcm_rdata),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 cpu_clk = ~cpu_clk;

   function automatic logic [31:0] itcm_word(input logic [13:0] w);
      return 32'h0000_0093 + {10'b0, w, 8'h00};
   endfunction

   function automatic logic [31:0] ahb_word(input logic [31:0] a);
      return 32'h0010_0513 ^ {a[29:2], 4'h0};
   endfunction

   // ITCM SRAM: data for a strobed word appears in the following cycle
   initial begin : itcm_model
      logic        cs_q;
      logic [13:0] a_q;
      cs_q = 1'b0; a_q = 14'h0; itcm_rdata = 32'h0;
      forever begin
         @(negedge cpu_clk);
         cs_q = itcm_cs; a_q = itcm_addr;
         @(posedge cpu_clk); #2;
         if (cs_q) itcm_rdata = itcm_word(a_q);
      end
   end

   // AHB slave: applies cfg_aw/cfg_dw/cfg_err to each transfer it sees start
   initial begin : ahb_model
      int          ph, cnt, aw, dw;
      bit          er, last_rdy;
      logic [31:0] ad;
      ph = 0; cnt = 0; aw = 0; dw = 0; er = 1'b0; ad = 32'h0; last_rdy = 1'b1;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
      forever begin
         @(posedge cpu_clk); #2;
         if (!cpu_rstn) begin
            ph = 0; HREADY = 1'b1; HRESP = 1'b0;
         end else begin
            if (ph == 1 && last_rdy) begin ph = 2; cnt = 0; end
            else if (ph == 2 && last_rdy) ph = 0;
            if (ph == 0 && HTRANS == 2'b10) begin
               ph = 1; cnt = 0; aw = cfg_aw; dw = cfg_dw; er = cfg_err; ad = HADDR;
            end
            if (ph == 1) begin
               HREADY = (cnt >= aw); HRESP = 1'b0; cnt++;
            end else if (ph == 2) begin
               if (cnt < dw) begin
                  HREADY = 1'b0; HRESP = er && (cnt == dw - 1);
               end else begin
                  HREADY = 1'b1; HRESP = er; HRDATA = er ? 32'hDEAD_BEEF : ahb_word(ad);
               end
               cnt++;
            end else begin
               HREADY = 1'b1; HRESP = 1'b0;
            end
         end
         last_rdy = HREADY;
      end
   end

   task automatic tick();
      @(posedge cpu_clk); #1;
   endtask

   // hold reset, then release it so the current cycle is cycle 1 (issue at pc)
   task automatic do_reset(input logic [31:0] pc);
      cpu_rstn = 1'b0; next_pc = pc;
      repeat (2) @(posedge cpu_clk);
      #1; cpu_rstn = 1'b1;
   endtask

   task automatic test_reset();
      cpu_rstn = 1'b0; next_pc = 32'h0;
      repeat (3) @(posedge cpu_clk);
      @(negedge cpu_clk);
      n_chk++; if (instr_read_data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_read_data_valid); end
      n_chk++; if (instr_read_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", instr_read_data); end
      n_chk++; if (addr_AHB !== 1'b0) begin n_fail++; $display("FAIL rst_addr_ahb: got %b want 0", addr_AHB); end
      n_chk++; if (instr_access_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", instr_access_fault); end
      n_chk++; if (itcm_cs !== 1'b0) begin n_fail++; $display("FAIL rst_itcm_cs: got %b want 0", itcm_cs); end
      n_chk++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %b want 00", HTRANS); end
      n_chk++; if (HADDR !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h want 0", HADDR); end
      n_chk++; if ({HWRITE, HSIZE, HBURST, HPROT} !== {1'b0, 3'b010, 3'b000, 4'b0010}) begin
         n_fail++; $display("FAIL ahb_consts: got %b want 00100000010", {HWRITE, HSIZE, HBURST, HPROT}); end
   endtask

   task automatic test_itcm_stream();
      do_reset(32'h0);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) tick();
         next_pc = 32'(4 * (k - 1)) + ((k == 3) ? 32'd2 : 32'd0);
         @(negedge cpu_clk);
         n_chk++; if (itcm_cs !== 1'b1) begin n_fail++; $display("FAIL itcm_cs k=%0d: got %b want 1", k, itcm_cs); end
         n_chk++; if (itcm_addr !== 14'(k - 1)) begin n_fail++; $display("FAIL itcm_addr k=%0d: got %0d want %0d", k, itcm_addr, k - 1); end
         n_chk++; if (instr_read_data_valid !== (k > 1)) begin n_fail++; $display("FAIL itcm_valid k=%0d: got %b want %b", k, instr_read_data_valid, k > 1); end
         if (k == 2) begin
            n_chk++; if (instr_read_data !== 32'h0000_0093) begin n_fail++; $display("FAIL itcm_first_data: got %h want 00000093", instr_read_data); end
         end
         if (k > 2) begin
            n_chk++; if (instr_read_data !== itcm_word(14'(k - 2))) begin n_fail++; $display("FAIL itcm_data k=%0d: got %h want %h", k, instr_read_data, itcm_word(14'(k - 2))); end
            n_chk++; if (addr_AHB !== 1'b0) begin n_fail++; $display("FAIL itcm_addr_ahb k=%0d: got %b want 0", k, addr_AHB); end
         end
      end
   endtask

   // one AHB fetch at 0x8000_0000 with aw/dw waits; valid expected at 3+aw+dw
   task automatic test_ahb_fetch(input int aw, input int dw);
      int lat;
      lat = 3 + aw + dw;
      cfg_aw = aw; cfg_dw = dw; cfg_err = 1'b0;
      do_reset(32'h8000_0000);
      for (int k = 1; k <= lat + 2; k++) begin
         if (k > 1) tick();
         @(negedge cpu_clk);
         n_chk++; if (instr_read_data_valid !== (k == lat + 1)) begin n_fail++; $display("FAIL ahb_valid aw=%0d dw=%0d k=%0d: got %b want %b", aw, dw, k, instr_read_data_valid, k == lat + 1); end
         n_chk++; if (addr_AHB !== 1'b1) begin n_fail++; $display("FAIL ahb_addr_ahb k=%0d: got %b want 1", k, addr_AHB); end
         n_chk++; if (HTRANS !== (((k >= 2 && k <= 2 + aw) || k == lat + 2) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL ahb_htrans aw=%0d dw=%0d k=%0d: got %b", aw, dw, k, HTRANS); end
         if (k >= 2 && k <= 2 + aw) begin
            n_chk++; if (HADDR !== 32'h8000_0000) begin n_fail++; $display("FAIL ahb_haddr k=%0d: got %h want 80000000", k, HADDR); end
         end
         if (k == lat + 1) begin
            n_chk++; if (instr_read_data !== 32'h0010_0513) begin n_fail++; $display("FAIL ahb_data: got %h want 00100513", instr_read_data); end
            n_chk++; if (instr_access_fault !== 1'b0) begin n_fail++; $display("FAIL ahb_fault: got %b want 0", instr_access_fault); end
         end
      end
   endtask

   task automatic test_ahb_error();
      cfg_aw = 0; cfg_dw = 1; cfg_err = 1'b1;
      do_reset(32'h8000_0010);
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) begin tick(); next_pc = 32'h0000_0020; end
         @(negedge cpu_clk);
         n_chk++; if (instr_read_data_valid !== (k >= 5)) begin n_fail++; $display("FAIL err_valid k=%0d: got %b want %b", k, instr_read_data_valid, k >= 5); end
         n_chk++; if (HTRANS !== ((k == 2) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL err_htrans k=%0d: got %b", k, HTRANS); end
         if (k == 5) begin
            n_chk++; if (instr_access_fault !== 1'b1) begin n_fail++; $display("FAIL err_fault: got %b want 1", instr_access_fault); end
            n_chk++; if (instr_read_data !== 32'h0000_0013) begin n_fail++; $display("FAIL err_data: got %h want 00000013", instr_read_data); end
            n_chk++; if (addr_AHB !== 1'b1) begin n_fail++; $display("FAIL err_addr_ahb: got %b want 1", addr_AHB); end
         end
         if (k == 6) begin
            n_chk++; if ({instr_access_fault, addr_AHB} !== 2'b00) begin n_fail++; $display("FAIL err_next_itcm flags: got %b want 00", {instr_access_fault, addr_AHB}); end
            n_chk++; if (instr_read_data !== itcm_word(14'd8)) begin n_fail++; $display("FAIL err_next_itcm data: got %h want %h", instr_read_data, itcm_word(14'd8)); end
         end
      end
   endtask

   task automatic test_alternate();
      logic [31:0] pcs [6];
      bit          ev  [6];
      bit          ea  [6];
      bit          ecs [6];
      logic [31:0] ed  [6];
      int          nval;
      pcs = '{32'h0000_0100, 32'h8000_0200, 32'h8000_0200, 32'h8000_0200, 32'h0000_0104, 32'h8000_0300};
      ev  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      ea  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ecs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ed  = '{32'h0, itcm_word(14'h40), 32'h0, 32'h0, ahb_word(32'h8000_0200), itcm_word(14'h41)};
      nval = 0;
      cfg_aw = 0; cfg_dw = 0; cfg_err = 1'b0;
      do_reset(32'h0000_0100);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         next_pc = pcs[k];
         @(negedge cpu_clk);
         if (instr_read_data_valid === 1'b1) nval++;
         n_chk++; if (instr_read_data_valid !== ev[k]) begin n_fail++; $display("FAIL alt_valid k=%0d: got %b want %b", k, instr_read_data_valid, ev[k]); end
         n_chk++; if (itcm_cs !== ecs[k]) begin n_fail++; $display("FAIL alt_itcm_cs k=%0d: got %b want %b", k, itcm_cs, ecs[k]); end
         if (ev[k]) begin
            n_chk++; if (addr_AHB !== ea[k]) begin n_fail++; $display("FAIL alt_addr_ahb k=%0d: got %b want %b", k, addr_AHB, ea[k]); end
            n_chk++; if (instr_read_data !== ed[k]) begin n_fail++; $display("FAIL alt_data k=%0d: got %h want %h", k, instr_read_data, ed[k]); end
         end
      end
      n_chk++; if (nval != 3) begin n_fail++; $display("FAIL alt_return_count: got %0d want 3", nval); end
   endtask

   task automatic test_reset_mid();
      cfg_aw = 0; cfg_dw = 5; cfg_err = 1'b0;
      do_reset(32'h8000_0040);
      tick(); tick();
      @(negedge cpu_clk);
      n_chk++; if ({addr_AHB, HTRANS} !== 3'b100) begin n_fail++; $display("FAIL mid_in_data: got %b want 100", {addr_AHB, HTRANS}); end
      tick();
      cpu_rstn = 1'b0; next_pc = 32'h0000_0008;
      @(negedge cpu_clk);
      n_chk++; if ({instr_read_data_valid, addr_AHB, instr_access_fault, itcm_cs, HTRANS} !== 6'b0) begin
         n_fail++; $display("FAIL mid_rst_flags: got %b want 000000", {instr_read_data_valid, addr_AHB, instr_access_fault, itcm_cs, HTRANS}); end
      n_chk++; if ({HADDR, instr_read_data} !== 64'h0) begin n_fail++; $display("FAIL mid_rst_bus: got %h want 0", {HADDR, instr_read_data}); end
      do_reset(32'h0000_0008);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) tick();
         @(negedge cpu_clk);
         n_chk++; if ({itcm_cs, itcm_addr} !== {1'b1, 14'd2}) begin n_fail++; $display("FAIL mid_reissue k=%0d: got %b/%0d want 1/2", k, itcm_cs, itcm_addr); end
         n_chk++; if ({instr_read_data_valid, addr_AHB} !== {k > 1, 1'b0}) begin n_fail++; $display("FAIL mid_valid k=%0d: got %b", k, {instr_read_data_valid, addr_AHB}); end
         if (k > 1) begin
            n_chk++; if (instr_read_data !== itcm_word(14'd2)) begin n_fail++; $display("FAIL mid_data k=%0d: got %h", k, instr_read_data); end
         end
      end
   endtask

   // random fetch stream checked against a request/latency model
   task automatic test_random();
      bit          m_busy, m_ahb, m_fault, issue, itcm, exp_valid, exp_ns, er;
      int          m_left, m_el, m_aw, aw, dw, r;
      logic [31:0] m_data, m_addr, pc;
      m_busy = 1'b0; m_ahb = 1'b0; m_fault = 1'b0; m_left = 0; m_el = 0; m_aw = 0;
      m_data = 32'h0; m_addr = 32'h0;
      do_reset(32'h0000_0000);
      for (int k = 0; k < 3000; k++) begin
         if (k > 0) tick();
         r = $urandom_range(0, 9);
         if (r < 4)      pc = $urandom & 32'h0000_FFFF;
         else if (r < 8) pc = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
         else if (r == 8) pc = 32'h0000_FFFC + 32'($urandom_range(0, 3));
         else            pc = 32'h0001_0000 + 32'($urandom_range(0, 3));
         if (k == 0) pc = 32'h0000_0000;
         next_pc = pc;
         exp_valid = m_busy && (m_left == 0);
         issue = !m_busy || exp_valid;
         itcm = (pc < 32'h0001_0000);
         aw = $urandom_range(0, 2); dw = $urandom_range(0, 3); er = ($urandom_range(0, 4) == 0);
         if (er && dw == 0) dw = 1;
         if (issue && !itcm) begin cfg_aw = aw; cfg_dw = dw; cfg_err = er; end
         exp_ns = m_busy && m_ahb && (m_el >= 1) && (m_el <= 1 + m_aw);
         @(negedge cpu_clk);
         n_chk++; if (instr_read_data_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d: got %b want %b", k, instr_read_data_valid, exp_valid); end
         if (exp_valid) begin
            n_chk++; if ({instr_read_data, addr_AHB, instr_access_fault} !== {m_data, m_ahb, m_fault}) begin
               n_fail++; $display("FAIL rnd_resp cyc=%0d: got %h/%b/%b want %h/%b/%b", k, instr_read_data, addr_AHB, instr_access_fault, m_data, m_ahb, m_fault); end
         end
         n_chk++; if (itcm_cs !== (issue && itcm)) begin n_fail++; $display("FAIL rnd_itcm_cs cyc=%0d: got %b want %b", k, itcm_cs, issue && itcm); end
         if (issue && itcm) begin
            n_chk++; if (itcm_addr !== pc[15:2]) begin n_fail++; $display("FAIL rnd_itcm_addr cyc=%0d: got %h want %h", k, itcm_addr, pc[15:2]); end
         end
         n_chk++; if (HTRANS !== (exp_ns ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL rnd_htrans cyc=%0d: got %b want %b", k, HTRANS, exp_ns ? 2'b10 : 2'b00); end
         if (exp_ns) begin
            n_chk++; if (HADDR !== m_addr) begin n_fail++; $display("FAIL rnd_haddr cyc=%0d: got %h want %h", k, HADDR, m_addr); end
         end
         if (issue) begin
            m_busy = 1'b1; m_el = 1; m_ahb = !itcm; m_addr = {pc[31:2], 2'b00};
            if (itcm) begin
               m_left = 0; m_data = itcm_word(pc[15:2]); m_fault = 1'b0; m_aw = 0;
            end else begin
               m_aw = aw; m_left = 2 + aw + dw; m_fault = er;
               m_data = er ? 32'h0000_0013 : ahb_word(m_addr);
            end
         end else begin
            m_left--; m_el++;
         end
      end
   endtask

   initial begin
      cpu_rstn = 1'b0; next_pc = 32'h0;
      test_reset();
      test_itcm_stream();
      test_ahb_fetch(0, 0);
      test_ahb_fetch(2, 3);
      test_ahb_error();
      test_alternate();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
